// File: rtl/word_transmitter_pkg.sv
// Shared definitions for the two-wire bootloader link (transmitter side).
package word_transmitter_pkg;

    // Link defaults, shared with the far-end word receiver.
    localparam int WORD_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 12;

    // Width of the strobe/gap timer; large enough for any practical divider.
    localparam int TIMER_W = 16;

    // Transmitter state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/word_transmitter_if.sv
// Parallel word handshake feeding the serial transmitter.
interface word_transmitter_if
    import word_transmitter_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] data_in;

    // Word producer side.
    modport master (
        output in_valid,
        output data_in,
        input  in_ready
    );

    // Transmitter side.
    modport slave (
        input  in_valid,
        input  data_in,
        output in_ready
    );
endinterface

// File: rtl/word_transmitter_strobe_timer.sv
// Reloadable down-counter: load a period, get a terminal-count flag on the
// last cycle of that period. A period of 1 gives terminal count immediately.
module word_transmitter_strobe_timer
    import word_transmitter_pkg::*;
#(
    parameter int CNT_W = TIMER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = period_i - CNT_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/word_transmitter.sv
// Serial word transmitter for the two-wire bootloader link. Words arrive over
// a valid/ready handshake and leave MSB-first on dataPin, qualified by the
// rising edge of dataOnPin, with a strobe-low gap after each word.
module word_transmitter
    import word_transmitter_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    word_transmitter_if.slave     wr,
    input  logic                  addr_clear,
    output logic                  dataPin,
    output logic                  dataOnPin,
    output logic                  busy,
    output logic                  word_done,
    output logic [ADDR_WIDTH-1:0] word_count
);

    localparam int BC_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [BC_W-1:0]    LAST_BIT   = BC_W'(WORD_WIDTH - 1);
    localparam logic [TIMER_W-1:0] DIV_PERIOD = TIMER_W'(CLK_DIV);
    localparam logic [TIMER_W-1:0] GAP_PERIOD = TIMER_W'(GAP_CYCLES);

    tx_state_e             state_q;
    logic [WORD_WIDTH-1:0] shift_q;
    logic [BC_W-1:0]       bit_cnt_q;
    logic                  data_pin_q;
    logic                  data_on_q;
    logic                  busy_q;
    logic                  word_done_q;
    logic                  in_ready_q;
    logic [ADDR_WIDTH-1:0] word_count_q;

    logic                  accept;
    logic                  last_bit;
    logic                  tmr_load;
    logic [TIMER_W-1:0]    tmr_period;
    logic                  tmr_tc;

    assign accept   = wr.in_valid & in_ready_q;
    assign last_bit = (bit_cnt_q == LAST_BIT);

    // Timer reload: start each SETUP/HIGH phase and the trailing gap.
    always_comb begin
        tmr_load   = 1'b0;
        tmr_period = DIV_PERIOD;
        case (state_q)
            ST_IDLE:  tmr_load = accept;
            ST_SETUP: tmr_load = tmr_tc;
            ST_HIGH: begin
                tmr_load = tmr_tc;
                if (last_bit) begin
                    tmr_period = GAP_PERIOD;
                end
            end
            default: tmr_load = 1'b0;
        endcase
    end

    word_transmitter_strobe_timer #(
        .CNT_W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (tmr_load),
        .period_i (tmr_period),
        .tc_o     (tmr_tc)
    );

    // Transmit FSM; every output is loaded with the value of the state entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            data_pin_q   <= 1'b0;
            data_on_q    <= 1'b0;
            busy_q       <= 1'b0;
            word_done_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            word_count_q <= '0;
        end else begin
            word_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shift_q    <= wr.data_in;
                        bit_cnt_q  <= '0;
                        data_pin_q <= wr.data_in[WORD_WIDTH-1];
                        data_on_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_tc) begin
                        data_on_q <= 1'b1;
                        state_q   <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tmr_tc) begin
                        data_on_q <= 1'b0;
                        if (last_bit) begin
                            data_pin_q <= 1'b0;
                            state_q    <= ST_GAP;
                        end else begin
                            // Next bit goes out together with the falling strobe.
                            shift_q    <= shift_q << 1;
                            bit_cnt_q  <= bit_cnt_q + BC_W'(1);
                            data_pin_q <= shift_q[WORD_WIDTH-2];
                            state_q    <= ST_SETUP;
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr_tc) begin
                        word_done_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        in_ready_q   <= 1'b1;
                        word_count_q <= word_count_q + ADDR_WIDTH'(1);
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Clear overrides a simultaneous increment.
            if (addr_clear) begin
                word_count_q <= '0;
            end
        end
    end

    assign wr.in_ready = in_ready_q;
    assign dataPin     = data_pin_q;
    assign dataOnPin   = data_on_q;
    assign busy        = busy_q;
    assign word_done   = word_done_q;
    assign word_count  = word_count_q;

endmodule

// File: doc/word_transmitter.md
Name: word_transmitter

Overview:
- Serial source for the two-wire bootloader link: dataPin carries the data bit, dataOnPin is the bit strobe.
- Accepts parallel words over a valid/ready handshake and shifts each one out MSB-first, one bit per strobe period, with an idle gap between words.
- Tracks the running word index that the far-end receiver uses as its write address.
- Used to stream program images into the FPGA bootloader from a host-side or test FPGA, and to loop back memory contents for bench verification.

Parameters:
- WORD_WIDTH, 32, bits per word.
- ADDR_WIDTH, 12, width of the word counter; matches the instruction ROM address width.
- CLK_DIV, 4, clk cycles per strobe half-period; must be >= 1.
- GAP_CYCLES, 8, clk cycles of strobe-low idle after the last bit of each word; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  data_in holds a word to send.
- in_ready  out  1  transmitter can accept a word; high only in IDLE.
- data_in  in  WORD_WIDTH  word to transmit; sampled on accept.
- addr_clear  in  1  synchronous clear of word_count.
- dataPin  out  1  serial data, MSB first.
- dataOnPin  out  1  bit strobe; the receiver samples dataPin on its rising edge.
- busy  out  1  high whenever the state is not IDLE.
- word_done  out  1  one-cycle pulse after a word's gap completes.
- word_count  out  ADDR_WIDTH  number of words fully sent, modulo 2^ADDR_WIDTH.

Behaviour:
- All outputs are registered.
- Reset values: dataPin=0, dataOnPin=0, busy=0, word_done=0, word_count=0, in_ready=1, state=IDLE.
- Reset mid-word aborts immediately. On the next edge all outputs take their reset values; the partial word is dropped and not counted.
- Accept occurs on a clk edge with in_valid & in_ready. At that edge:
  - shift register <= data_in;
  - bit_cnt <= 0;
  - div_cnt <= 0;
  - state <= SETUP.
- SETUP: lasts CLK_DIV cycles. dataOnPin=0 and dataPin=shift[WORD_WIDTH-1]; the data bit is stable for the whole low phase. Then go to HIGH.
- HIGH: lasts CLK_DIV cycles. dataOnPin=1 and dataPin is held.
  - On the last HIGH cycle with bit_cnt==WORD_WIDTH-1: go to GAP.
  - Otherwise: shift left by 1, bit_cnt+1, go to SETUP.
- GAP: lasts GAP_CYCLES cycles with dataOnPin=0 and dataPin=0. Then go to IDLE, pulse word_done for that one cycle, and increment word_count.
- IDLE: dataOnPin=0, dataPin=0, in_ready=1.
- Timing:
  - The first SETUP cycle follows the accept edge.
  - Word duration is 2*CLK_DIV*WORD_WIDTH + GAP_CYCLES cycles.
  - Minimum back-to-back period is that duration + 1, since accept can occur in the same cycle word_done is high.
- data_in and in_valid are ignored while busy; no queuing.
- word_count wraps from 2^ADDR_WIDTH-1 to 0 with no flag.
- addr_clear is honoured in any state. If it coincides with the increment, the clear wins and word_count=0.
- dataOnPin never glitches: exactly WORD_WIDTH rising edges per word, and no rising edge occurs within a cycle of a dataPin change.

Decomposition:
- Shared package holds:
  - WORD_WIDTH and ADDR_WIDTH defaults, shared with wordReceiver;
  - the state encoding IDLE/SETUP/HIGH/GAP, 2 bits.
- One natural sub-module, strobe_timer: a div counter with a load value (CLK_DIV or GAP_CYCLES) and a terminal-count pulse. It is reused by any future link-rate logic.

Test Plan:
- CLK_DIV=2, GAP_CYCLES=4, send 32'hA5000001 -> 32 strobe rises, sampled bits equal A5000001 MSB-first; word_done pulses exactly 132 cycles after the accept edge; word_count=1.
- Loopback into wordReceiver, 3 words 32'h00000013 / 32'hDEADBEEF / 32'hFFFFFFFF held valid continuously -> receiver out/addr show (0,13), (1,DEADBEEF), (2,FFFFFFFF); accepts are spaced exactly 133 cycles apart.
- Assert reset at bit 10 of 32'h12345678 -> next edge dataOnPin=0, busy=0, word_count=0. A subsequent 32'h0000000F then transmits cleanly.
- Preload word_count to 4095 by sending 4095 words, send one more -> word_count=0 and word_done pulses.
- Assert addr_clear in the same cycle as word_done with word_count=6 -> word_count=0, not 7.
- Toggle in_valid with changing data_in while busy -> the transmitted word is unchanged and in_ready stays 0 until IDLE.
